// File: rtl/blink_sequencer.sv
// blink_sequencer: LED pattern sequencer with prescaler and valid/ready commands; `define BLINK_SEQ_LFSR_EN turns mode 3 into an LFSR
module blink_sequencer #(
    parameter int BASE_DIV = 24999999,
    parameter int PRE_W    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_rate,
    input  logic       pause,
    output logic [7:0] led_out,
    output logic       tick_out,
    output logic [1:0] state_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, PAUSED = 2'd3} state_t;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BASE_DIV);
    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       rcnt_q, rcnt_d, rate_q, rate_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d, tick_q, tick_d;
    logic [7:0]       led_q, led_d, bounce_v, alt_v, alt_init, init_v, step_v;
    logic             accept, bounce_dir;
`ifdef BLINK_SEQ_LFSR_EN
    assign alt_v    = {led_q[6:0], led_q[7] ^ led_q[5] ^ led_q[4] ^ led_q[3]};
    assign alt_init = 8'h01;
`else
    assign alt_v    = ~led_q;
    assign alt_init = 8'h00;
`endif
    assign bounce_v   = dir_q ? (led_q == 8'h01 ? 8'h02 : led_q >> 1) : (led_q == 8'h80 ? 8'h40 : led_q << 1);
    assign bounce_dir = dir_q ? (led_q != 8'h01) : (led_q == 8'h80);
    assign init_v     = mode_q == 2'd0 ? 8'h00 : mode_q == 2'd1 ? 8'hFF : mode_q == 2'd2 ? 8'h01 : alt_init;
    assign step_v     = mode_q == 2'd0 ? led_q + 8'd1 : mode_q == 2'd1 ? led_q - 8'd1 : mode_q == 2'd2 ? bounce_v : alt_v;
    assign cmd_ready  = state_q != LOAD;
    assign accept     = cmd_valid & cmd_ready & ena;
    assign led_out    = led_q;
    assign tick_out   = tick_q;
    assign state_out  = state_q;

    // next state: command accept beats stepping and pause; ena low freezes everything
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rcnt_d  = rcnt_q;
        mode_d  = mode_q;
        rate_d  = rate_q;
        dir_d   = dir_q;
        led_d   = led_q;
        tick_d  = 1'b0;
        if (ena) begin
            if (accept) begin
                state_d = LOAD;
                mode_d  = cmd_mode;
                rate_d  = cmd_rate;
            end else begin
                case (state_q)
                    LOAD: begin
                        pre_d   = '0;
                        rcnt_d  = '0;
                        dir_d   = 1'b0;
                        led_d   = init_v;
                        state_d = pause ? PAUSED : RUN;
                    end
                    RUN: begin
                        if (pause) begin
                            state_d = PAUSED;
                        end else if (pre_q == PRE_MAX) begin
                            pre_d = '0;
                            if (rcnt_q == rate_q) begin
                                rcnt_d = '0;
                                led_d  = step_v;
                                dir_d  = mode_q == 2'd2 ? bounce_dir : dir_q;
                                tick_d = 1'b1;
                            end else begin
                                rcnt_d = rcnt_q + 4'd1;
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                    PAUSED: state_d = pause ? PAUSED : RUN;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rcnt_q  <= '0;
            mode_q  <= '0;
            rate_q  <= '0;
            dir_q   <= 1'b0;
            led_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rcnt_q  <= rcnt_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: vector table, corner sequences and randomized run against a period-based reference model
module tb_blink_sequencer;
    localparam int BD = 3;
`ifdef BLINK_SEQ_LFSR_EN
    localparam logic [7:0] ALT0 = 8'h01, ALT1 = 8'h02;
`else
    localparam logic [7:0] ALT0 = 8'h00, ALT1 = 8'hFF;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, cmd_valid = 1'b0, pause = 1'b0;
    logic [1:0] cmd_mode = '0;
    logic [3:0] cmd_rate = '0;
    logic cmd_ready, tick_out;
    logic [7:0] led_out;
    logic [1:0] state_out;
    int n_chk = 0, n_pass = 0;
    int m_state = 0, m_prog = 0, m_mode = 0, m_rate = 0, m_led = 0, m_pos = 0, m_tick = 0;
    bit m_left = 1;

    blink_sequencer #(.BASE_DIV(BD), .PRE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_rate(cmd_rate), .pause(pause), .led_out(led_out),
        .tick_out(tick_out), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n, ena, valid;
        logic [1:0] mode;
        logic [3:0] rate;
        logic pause;
        int n;
        logic [7:0] led;
        logic [1:0] st;
        logic rdy, tk;
    } vec_t;
    vec_t vt[24];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic advance();
        int b;
        case (m_mode)
            0: m_led = (m_led + 1) % 256;
            1: m_led = (m_led + 255) % 256;
            2: begin
                if (m_left) begin
                    if (m_pos == 7) begin m_pos = 6; m_left = 0; end else m_pos++;
                end else begin
                    if (m_pos == 0) begin m_pos = 1; m_left = 1; end else m_pos--;
                end
                m_led = 1 << m_pos;
            end
            default: begin
`ifdef BLINK_SEQ_LFSR_EN
                b = ((m_led >> 7) ^ (m_led >> 5) ^ (m_led >> 4) ^ (m_led >> 3)) & 1;
                m_led = ((m_led << 1) | b) % 256;
`else
                b = 0;
                m_led = 255 - m_led;
`endif
            end
        endcase
    endtask

    task automatic model();
        int period;
        m_tick = 0;
        if (!rst_n) begin
            m_state = 0; m_prog = 0; m_mode = 0; m_rate = 0; m_led = 0; m_pos = 0; m_left = 1;
        end else if (ena) begin
            if (cmd_valid && m_state != 1) begin
                m_state = 1; m_mode = int'(cmd_mode); m_rate = int'(cmd_rate);
            end else if (m_state == 1) begin
                m_prog = 0; m_pos = 0; m_left = 1;
                m_led = m_mode == 0 ? 0 : m_mode == 1 ? 255 : m_mode == 2 ? 1 : int'(ALT0);
                m_state = pause ? 3 : 2;
            end else if (m_state == 2) begin
                period = (BD + 1) * (m_rate + 1);
                if (pause) m_state = 3;
                else if (m_prog == period - 1) begin m_prog = 0; advance(); m_tick = 1; end
                else m_prog++;
            end else if (m_state == 3 && !pause) m_state = 2;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        chk("model_led", int'(led_out), m_led);
        chk("model_tick", int'(tick_out), m_tick);
        chk("model_state", int'(state_out), m_state);
        chk("model_ready", int'(cmd_ready), m_state != 1 ? 1 : 0);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [1:0] m, input logic [3:0] rt, input logic p);
        rst_n = r; ena = e; cmd_valid = v; cmd_mode = m; cmd_rate = rt; pause = p;
    endtask

    initial begin
        bit seen_zero;
        vt[0]  = '{1'b0, 1'b1, 1'b1, 2'd1, 4'd5, 1'b0, 2,  8'h00, 2'd0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 3,  8'h00, 2'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1,  8'h00, 2'd1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 1,  8'h00, 2'd2, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 8,  8'h01, 2'd2, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 1,  8'h01, 2'd2, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 7,  8'h02, 2'd2, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b1, 1,  8'h02, 2'd3, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b1, 19, 8'h02, 2'd3, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 1,  8'h02, 2'd2, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 8,  8'h03, 2'd2, 1'b1, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 10, 8'h03, 2'd2, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 8,  8'h04, 2'd2, 1'b1, 1'b1};
        vt[13] = '{1'b1, 1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 1,  8'h04, 2'd1, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1,  8'h01, 2'd2, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 4,  8'h02, 2'd2, 1'b1, 1'b1};
        vt[16] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 24, 8'h80, 2'd2, 1'b1, 1'b1};
        vt[17] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 4,  8'h40, 2'd2, 1'b1, 1'b1};
        vt[18] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 24, 8'h01, 2'd2, 1'b1, 1'b1};
        vt[19] = '{1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 4,  8'h02, 2'd2, 1'b1, 1'b1};
        vt[20] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'd0, 1'b0, 1,  8'h02, 2'd1, 1'b0, 1'b0};
        vt[21] = '{1'b1, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0, 1,  ALT0, 2'd2, 1'b1, 1'b0};
        vt[22] = '{1'b1, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0, 4,  ALT1, 2'd2, 1'b1, 1'b1};
        vt[23] = '{1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1,  8'h00, 2'd0, 1'b1, 1'b0};
        for (int i = 0; i < 24; i++) begin
            drive(vt[i].rst_n, vt[i].ena, vt[i].valid, vt[i].mode, vt[i].rate, vt[i].pause);
            repeat (vt[i].n) cyc();
            chk($sformatf("vec%0d_led", i), int'(led_out), int'(vt[i].led));
            chk($sformatf("vec%0d_state", i), int'(state_out), int'(vt[i].st));
            chk($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(vt[i].rdy));
            chk($sformatf("vec%0d_tick", i), int'(tick_out), int'(vt[i].tk));
        end
        // collision: command in the exact step-event cycle
        drive(1, 1, 1, 2'd0, 4'd0, 0); cyc();
        drive(1, 1, 0, 2'd0, 4'd0, 0); cyc();
        repeat (3) cyc();
        drive(1, 1, 1, 2'd1, 4'd0, 0); cyc();
        chk("coll_led", int'(led_out), 8'h00);
        chk("coll_tick", int'(tick_out), 0);
        chk("coll_state", int'(state_out), 1);
        drive(1, 1, 0, 2'd1, 4'd0, 0); cyc();
        chk("coll_load_led", int'(led_out), 8'hFF);
        repeat (4) cyc();
        chk("coll_next_led", int'(led_out), 8'hFE);
        chk("coll_next_tick", int'(tick_out), 1);
        // count-up wrap at tick 256
        drive(1, 1, 1, 2'd0, 4'd1, 0); cyc();
        drive(1, 1, 0, 2'd0, 4'd1, 0); cyc();
        repeat (8 * 255) cyc();
        chk("wrap_ff", int'(led_out), 8'hFF);
        repeat (8) cyc();
        chk("wrap_00", int'(led_out), 8'h00);
        chk("wrap_tick", int'(tick_out), 1);
`ifdef BLINK_SEQ_LFSR_EN
        drive(1, 1, 1, 2'd3, 4'd0, 0); cyc();
        drive(1, 1, 0, 2'd3, 4'd0, 0); cyc();
        seen_zero = 0;
        repeat (255 * 4) begin cyc(); if (led_out == 8'h00) seen_zero = 1; end
        chk("lfsr_period", int'(led_out), 8'h01);
        chk("lfsr_nonzero", int'(seen_zero), 0);
`else
        seen_zero = 0;
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) != 0, $urandom_range(7) != 0, $urandom_range(15) == 0,
                  2'($urandom_range(3)), 4'($urandom_range(3)), $urandom_range(7) == 0);
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Controller for the LED blink datapath: owns the prescaler and the 8-bit LED pattern register, and sequences the pattern at a programmable rate.
- Host logic, e.g. the tt_um top driving from ui_in, issues mode/rate commands over a valid/ready handshake.
- The block applies each command atomically and drives uo_out-style LED outputs plus a tick strobe.

Parameters:
- BASE_DIV, 24999999, prescaler terminal count; base tick every BASE_DIV+1 clocks.
- PRE_W, 25, prescaler counter width; must hold BASE_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- ena  input  1  global enable; low freezes all counters, the pattern and the FSM (handshake still answers, see Behaviour)
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command can be accepted this cycle
- cmd_mode  input  2  0 count-up, 1 count-down, 2 bounce, 3 toggle (or LFSR, see Optional Feature)
- cmd_rate  input  4  rate divider; tick period = (BASE_DIV+1)*(cmd_rate+1) clocks
- pause  input  1  level; holds sequencing while high
- led_out  output  8  current pattern (registered)
- tick_out  output  1  one-cycle pulse, high in the cycle the new led_out value first appears
- state_out  output  2  FSM state encoding, for debug

Behaviour:
- Reset values (synchronous rst_n low at a clk edge):
  - state=IDLE(0); led_out=0x00; tick_out=0; cmd_ready=1.
  - Prescaler, rate counter, mode_reg, rate_reg and bounce direction all reset to 0.
- FSM states: IDLE=0, LOAD=1, RUN=2, PAUSED=3.
- cmd_ready=1 in IDLE, RUN and PAUSED; cmd_ready=0 in LOAD.
- Accept = cmd_valid & cmd_ready & ena. cmd_mode/cmd_rate are captured into mode_reg/rate_reg on the accept edge; the next state is LOAD.
- LOAD (exactly one cycle):
  - Clear prescaler and rate counter; clear bounce direction to "left".
  - Initialise led_out per mode: up 0x00, down 0xFF, bounce 0x01, toggle 0x00.
  - Next state is PAUSED if pause=1, else RUN.
- RUN:
  - Prescaler increments each cycle; at BASE_DIV it wraps to 0 and the rate counter increments.
  - Step event = prescaler==BASE_DIV and rate counter==rate_reg; both counters wrap to 0 on it.
  - On a step event led_out advances one step and tick_out=1 in the following cycle.
  - pause=1 -> PAUSED with counters held (no clear).
- PAUSED: counters and led_out hold; pause=0 -> RUN, resuming from the held counts.
- IDLE: counters and led_out hold at 0; leaves only on command accept.
- Pattern step rules (all 8-bit, wrapping):
  - up: +1, 0xFF->0x00.
  - down: -1, 0x00->0xFF.
  - bounce: single set bit shifts in the current direction; at 0x80 heading left the next value is 0x40 and direction becomes right; at 0x01 heading right the next value is 0x02 and direction becomes left.
  - toggle: led_out ^ 0xFF.
- Simultaneous events:
  - A command accepted in the same cycle as a step event wins: no step occurs and LOAD reinitialises.
  - Accept has priority over the pause transition.
- ena=0: no state, counter or pattern change; cmd_ready still reflects the state, but no accept occurs; tick_out=0.
- Reset mid-operation: returns to the reset values on that edge, regardless of state or pending cmd_valid.
- rate_reg=0 gives period BASE_DIV+1; rate_reg=15 gives 16*(BASE_DIV+1).

Optional Feature:
- Macro BLINK_SEQ_LFSR_EN.
- Defined: mode 3 is an 8-bit Fibonacci LFSR.
  - LOAD seeds 0x01.
  - Step: led_out <= {led_out[6:0], led_out[7]^led_out[5]^led_out[4]^led_out[3]}.
  - The sequence never reaches 0x00; period 255.
- Undefined: mode 3 is toggle as above; no LFSR logic is synthesised.

Test Plan (BASE_DIV=3):
- Reset: hold rst_n=0 for 2 clocks with cmd_valid=1 -> led_out=0x00, state_out=0, cmd_ready=1, tick_out=0; no accept.
- Count-up: accept mode=0, rate=1 -> one LOAD cycle with cmd_ready=0, then tick_out every 8 clocks; led_out 0x01, 0x02, 0x03, ...; wraps 0xFF->0x00 at tick 256.
- Bounce: accept mode=2, rate=0 -> ticks every 4 clocks; led_out 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02.
- Pause/ena: in RUN, raise pause for 20 clocks -> led_out and tick frozen; release -> next tick lands at the remaining count. Repeat with ena=0 -> same hold behaviour.
- Collision: assert cmd_valid (mode=1) in the exact step-event cycle -> no increment; led_out=0xFF after LOAD, then 0xFE at the next tick.
- LFSR (macro defined): mode=3, rate=0 -> led_out 0x01, 0x02, 0x04, 0x08, 0x11 on successive ticks; returns to 0x01 after 255 ticks; 0x00 is never seen.
